// File: rtl/param_tri_net_resolver_if.sv
// Driver/bus bundle for param_tri_net_resolver: per-driver enables and data in,
// resolved registered bus and arbitration status out.
interface param_tri_net_resolver_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 8
);
    logic [N-1:0]   drv_en;
    logic [N*W-1:0] drv_data;
    logic           cnt_clr;
    logic [W-1:0]   bus_q;
    logic           bus_driven;
    logic [N-1:0]   grant;
    logic           contention;
    logic [CW-1:0]  conflict_cnt;

    modport master (
        output drv_en, drv_data, cnt_clr,
        input  bus_q, bus_driven, grant, contention, conflict_cnt
    );

    modport slave (
        input  drv_en, drv_data, cnt_clr,
        output bus_q, bus_driven, grant, contention, conflict_cnt
    );
endinterface

// File: rtl/param_tri_net_resolver.sv
// Clocked resolver that replaces multi-driver tri0/tri1/triand/trior/trireg nets:
// round-robin single-winner or AND/OR merge, with contention counting and charge hold.
module param_tri_net_resolver #(
    parameter int W          = 8,
    parameter int N          = 4,
    parameter int MODE       = 0,
    parameter int EN_ACT_LOW = 1,
    parameter int CW         = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    param_tri_net_resolver_if.slave bus
);
    localparam int          PW      = (N > 1) ? $clog2(N) : 1;
    localparam bit          SINGLE  = (MODE == 0) || (MODE == 1) || (MODE == 4);
    localparam logic [W-1:0] RST_BUS = (MODE == 1) ? {W{1'b1}} : {W{1'b0}};

    if ((MODE < 0) || (MODE > 4) || (N < 2) || (N > 16) || (W < 1)) begin : g_bad_param
        $error("param_tri_net_resolver: illegal MODE/N/W parameter");
    end

    logic [N-1:0]  en_s;
    logic          any_s;
    logic          multi_s;
    logic [PW-1:0] winner_s;
    logic [W-1:0]  win_data_s;
    logic [W-1:0]  and_s;
    logic [W-1:0]  or_s;
    logic [W-1:0]  bus_q_nxt_s;
    logic [N-1:0]  grant_nxt_s;
    logic [PW-1:0] rr_ptr_nxt_s;
    logic          contention_nxt_s;
    logic [CW-1:0] cnt_nxt_s;

    logic [W-1:0]  bus_q_r;
    logic          bus_driven_r;
    logic [N-1:0]  grant_r;
    logic          contention_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] rr_ptr_r;

    assign en_s    = (EN_ACT_LOW != 0) ? ~bus.drv_en : bus.drv_en;
    assign any_s   = |en_s;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi_s = ((en_s & (en_s - {{(N-1){1'b0}}, 1'b1})) != {N{1'b0}});

    // Round-robin scan starting at rr_ptr for the first enabled driver.
    always_comb begin
        logic found_v;
        int   idx_v;
        winner_s = {PW{1'b0}};
        found_v  = 1'b0;
        idx_v    = 0;
        for (int off = 0; off < N; off++) begin
            idx_v = int'(rr_ptr_r) + off;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && en_s[idx_v]) begin
                found_v  = 1'b1;
                winner_s = PW'(idx_v);
            end else begin
                found_v = found_v;
            end
        end
    end

    assign win_data_s = bus.drv_data[int'(winner_s)*W +: W];

    // Wired-AND / wired-OR merge over the enabled drivers.
    always_comb begin
        and_s = {W{1'b1}};
        or_s  = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (en_s[i]) begin
                and_s = and_s & bus.drv_data[i*W +: W];
                or_s  = or_s  | bus.drv_data[i*W +: W];
            end else begin
                and_s = and_s;
                or_s  = or_s;
            end
        end
    end

    // Next-state selection for bus value, grant, pointer and contention counter.
    always_comb begin
        bus_q_nxt_s      = bus_q_r;
        grant_nxt_s      = {N{1'b0}};
        rr_ptr_nxt_s     = rr_ptr_r;
        contention_nxt_s = SINGLE && multi_s;
        if (any_s) begin
            if (SINGLE) begin
                bus_q_nxt_s = win_data_s;
                grant_nxt_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
            end else begin
                bus_q_nxt_s = (MODE == 2) ? and_s : or_s;
                grant_nxt_s = en_s;
            end
        end else begin
            case (MODE)
                0:       bus_q_nxt_s = {W{1'b0}};
                1:       bus_q_nxt_s = {W{1'b1}};
                default: bus_q_nxt_s = bus_q_r;   // charge retention
            endcase
        end
        if (SINGLE && multi_s) begin
            rr_ptr_nxt_s = (winner_s == PW'(N-1)) ? {PW{1'b0}} : winner_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
        if (bus.cnt_clr) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (contention_nxt_s && (cnt_r != {CW{1'b1}})) begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output and arbitration state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q_r      <= RST_BUS;
            bus_driven_r <= 1'b0;
            grant_r      <= {N{1'b0}};
            contention_r <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            rr_ptr_r     <= {PW{1'b0}};
        end else begin
            bus_q_r      <= bus_q_nxt_s;
            bus_driven_r <= any_s;
            grant_r      <= grant_nxt_s;
            contention_r <= contention_nxt_s;
            cnt_r        <= cnt_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
        end
    end

    assign bus.bus_q        = bus_q_r;
    assign bus.bus_driven   = bus_driven_r;
    assign bus.grant        = grant_r;
    assign bus.contention   = contention_r;
    assign bus.conflict_cnt = cnt_r;
endmodule

// File: tb/tb_param_tri_net_resolver.sv
// Directed bench: one resolver per mode (plus a CW=2 instance) all fed the same
// driver stimulus, outputs compared against hand-computed values.
module tb_param_tri_net_resolver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en_v;
    logic [31:0] data_v;
    logic        clr_v;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    param_tri_net_resolver_if #(.W(8), .N(4), .CW(8)) if0 ();
    param_tri_net_resolver_if #(.W(8), .N(4), .CW(8)) if1 ();
    param_tri_net_resolver_if #(.W(8), .N(4), .CW(8)) if2 ();
    param_tri_net_resolver_if #(.W(8), .N(4), .CW(8)) if3 ();
    param_tri_net_resolver_if #(.W(8), .N(4), .CW(8)) if4 ();
    param_tri_net_resolver_if #(.W(8), .N(4), .CW(2)) ifc ();

    assign if0.drv_en = en_v; assign if0.drv_data = data_v; assign if0.cnt_clr = clr_v;
    assign if1.drv_en = en_v; assign if1.drv_data = data_v; assign if1.cnt_clr = clr_v;
    assign if2.drv_en = en_v; assign if2.drv_data = data_v; assign if2.cnt_clr = clr_v;
    assign if3.drv_en = en_v; assign if3.drv_data = data_v; assign if3.cnt_clr = clr_v;
    assign if4.drv_en = en_v; assign if4.drv_data = data_v; assign if4.cnt_clr = clr_v;
    assign ifc.drv_en = en_v; assign ifc.drv_data = data_v; assign ifc.cnt_clr = clr_v;

    param_tri_net_resolver #(.W(8), .N(4), .MODE(0), .EN_ACT_LOW(1), .CW(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    param_tri_net_resolver #(.W(8), .N(4), .MODE(1), .EN_ACT_LOW(1), .CW(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    param_tri_net_resolver #(.W(8), .N(4), .MODE(2), .EN_ACT_LOW(1), .CW(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    param_tri_net_resolver #(.W(8), .N(4), .MODE(3), .EN_ACT_LOW(1), .CW(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    param_tri_net_resolver #(.W(8), .N(4), .MODE(4), .EN_ACT_LOW(1), .CW(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    param_tri_net_resolver #(.W(8), .N(4), .MODE(0), .EN_ACT_LOW(1), .CW(2)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [7:0] exp_d [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_d[0] = 8'h11;   exp_d[1] = 8'h22;   exp_d[2] = 8'h33;   exp_d[3] = 8'h44;   exp_d[4] = 8'h11;

        // Reset
        rst_n = 1'b0; en_v = 4'b0000; data_v = 32'h4433_2211; clr_v = 1'b0;
        tick(); tick();
        check_val("rst_m1_bus",   32'(if1.bus_q), 32'h0000_00FF);
        check_val("rst_m1_grant", 32'(if1.grant), 32'h0);
        check_val("rst_m1_cnt",   32'(if1.conflict_cnt), 32'h0);
        check_val("rst_m0_bus",   32'(if0.bus_q), 32'h0);
        check_val("rst_m0_drv",   32'(if0.bus_driven), 32'h0);
        check_val("rst_m0_cont",  32'(if0.contention), 32'h0);
        rst_n = 1'b1;

        // Single driver (driver 1) in all modes
        en_v = 4'b1101; data_v = {8'h00, 8'h00, 8'h5A, 8'h00};
        tick();
        check_val("one_m0_bus",   32'(if0.bus_q), 32'h5A);
        check_val("one_m0_grant", 32'(if0.grant), 32'b0010);
        check_val("one_m0_cont",  32'(if0.contention), 32'h0);
        check_val("one_m0_drv",   32'(if0.bus_driven), 32'h1);
        check_val("one_m2_bus",   32'(if2.bus_q), 32'h5A);
        check_val("one_m3_bus",   32'(if3.bus_q), 32'h5A);

        // All drivers enabled: round-robin rotation with wrap, saturating CW=2 counter
        en_v = 4'b0000; data_v = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("rr_grant", 32'(if0.grant), 32'(exp_g[i]));
            check_val("rr_bus",   32'(if0.bus_q), 32'(exp_d[i]));
            check_val("rr_cont",  32'(if0.contention), 32'h1);
            check_val("sat_cnt",  32'(ifc.conflict_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        check_val("rr_cnt5",     32'(if0.conflict_cnt), 32'd5);
        check_val("all_m2_bus",  32'(if2.bus_q), 32'h00);
        check_val("all_m3_bus",  32'(if3.bus_q), 32'h77);
        check_val("all_m2_gnt",  32'(if2.grant), 32'b1111);
        check_val("all_m2_cont", 32'(if2.contention), 32'h0);

        // Clear wins over simultaneous contention
        clr_v = 1'b1;
        tick();
        check_val("clr_c_cnt",  32'(ifc.conflict_cnt), 32'h0);
        check_val("clr_m0_cnt", 32'(if0.conflict_cnt), 32'h0);
        check_val("clr_m0_cont", 32'(if0.contention), 32'h1);
        check_val("clr_m0_gnt", 32'(if0.grant), 32'b0010);
        clr_v = 1'b0;

        // Trireg charge hold
        en_v = 4'b1110; data_v = {8'h00, 8'h00, 8'h00, 8'h3C};
        tick();
        check_val("trireg_drive", 32'(if4.bus_q), 32'h3C);
        en_v = 4'b1111; data_v = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("trireg_hold", 32'(if4.bus_q), 32'h3C);
            check_val("trireg_drv",  32'(if4.bus_driven), 32'h0);
            check_val("trireg_gnt",  32'(if4.grant), 32'h0);
        end
        check_val("undrv_m0_bus", 32'(if0.bus_q), 32'h00);
        check_val("undrv_m1_bus", 32'(if1.bus_q), 32'hFF);
        check_val("undrv_m2_bus", 32'(if2.bus_q), 32'h3C);

        // Two-driver merge; mode 0 arbitrates from rr_ptr=2 so driver 0 wins
        en_v = 4'b1100; data_v = {8'hAA, 8'h55, 8'h3C, 8'hF0};
        tick();
        check_val("and_bus",   32'(if2.bus_q), 32'h30);
        check_val("or_bus",    32'(if3.bus_q), 32'hFC);
        check_val("and_cont",  32'(if2.contention), 32'h0);
        check_val("or_cont",   32'(if3.contention), 32'h0);
        check_val("or_gnt",    32'(if3.grant), 32'b0011);
        check_val("pair_m0_gnt", 32'(if0.grant), 32'b0001);
        check_val("pair_m0_bus", 32'(if0.bus_q), 32'hF0);

        // Reset mid-arbitration discards rr_ptr (currently 1)
        rst_n = 1'b0; en_v = 4'b0000; data_v = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        check_val("mid_rst_cnt", 32'(if0.conflict_cnt), 32'h0);
        check_val("mid_rst_gnt", 32'(if0.grant), 32'h0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_gnt", 32'(if0.grant), 32'b0001);
        check_val("post_rst_bus", 32'(if0.bus_q), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
